// File: rtl/grf_wb_arbiter.sv
// Writeback arbiter for the single GRF write port: pipeline (P) has fixed priority,
// the mult/div unit (M) is granted after STARVE_LIMIT consecutive blocked cycles.
module grf_wb_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p_valid,
   output logic             p_ready,
   input  logic [4:0]       p_a3,
   input  logic [31:0]      p_wd,
   input  logic [31:0]      p_pc,
   input  logic             m_valid,
   output logic             m_ready,
   input  logic [4:0]       m_a3,
   input  logic [31:0]      m_wd,
   input  logic [31:0]      m_pc,
   output logic             grf_we,
   output logic [4:0]       grf_a3,
   output logic [31:0]      grf_wd,
   output logic [31:0]      grf_pc,
   input  logic [4:0]       q_a,
   output logic             q_hit,
   output logic [31:0]      q_wd,
   output logic [CNT_W-1:0] starve_cnt
);

   typedef enum logic [0:0] {
      NORMAL  = 1'b0,
      FORCE_M = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             p_xfer_s;
   logic             m_xfer_s;
   logic [4:0]       win_a3_s;
   logic [31:0]      win_wd_s;
   logic [31:0]      win_pc_s;

   assign p_xfer_s = p_valid && p_ready;
   assign m_xfer_s = m_valid && m_ready;

   // State and starvation counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= NORMAL;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next state: count blocked M cycles, force one M grant once the limit is reached
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         NORMAL: begin
            if (!m_valid || m_xfer_s) begin
               cnt_nxt_s = {CNT_W{1'b0}};
            end else if (cnt_r >= (LIMIT - CNT_W'(1))) begin
               cnt_nxt_s   = LIMIT;
               state_nxt_s = FORCE_M;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         FORCE_M: begin
            // A dropped m_valid is tolerated: fall back rather than lock P out
            if (!m_valid || m_xfer_s) begin
               cnt_nxt_s   = {CNT_W{1'b0}};
               state_nxt_s = NORMAL;
            end else begin
               cnt_nxt_s   = cnt_r;
               state_nxt_s = FORCE_M;
            end
         end
         default: begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = NORMAL;
         end
      endcase
   end

   // Ready outputs decoded from the current state
   always_comb begin
      p_ready = 1'b1;
      m_ready = !p_valid;
      case (state_r)
         NORMAL: begin
            p_ready = 1'b1;
            m_ready = !p_valid;
         end
         FORCE_M: begin
            p_ready = 1'b0;
            m_ready = 1'b1;
         end
         default: begin
            p_ready = 1'b1;
            m_ready = !p_valid;
         end
      endcase
   end

   // Winner field select; grants are mutually exclusive so M transfer picks M
   always_comb begin
      if (m_xfer_s) begin
         win_a3_s = m_a3;
         win_wd_s = m_wd;
         win_pc_s = m_pc;
      end else begin
         win_a3_s = p_a3;
         win_wd_s = p_wd;
         win_pc_s = p_pc;
      end
   end

   // Registered GRF write; writes to r0 complete the handshake but never assert WE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grf_we <= 1'b0;
         grf_a3 <= 5'd0;
         grf_wd <= 32'd0;
         grf_pc <= 32'd0;
      end else if ((p_xfer_s || m_xfer_s) && (win_a3_s != 5'd0)) begin
         grf_we <= 1'b1;
         grf_a3 <= win_a3_s;
         grf_wd <= win_wd_s;
         grf_pc <= win_pc_s;
      end else begin
         grf_we <= 1'b0;
      end
   end

   assign q_hit      = grf_we && (grf_a3 == q_a) && (q_a != 5'd0);
   assign q_wd       = grf_wd;
   assign starve_cnt = cnt_r;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: expected GRF writes are queued when a grant
// is expected and compared by a monitor one edge later.
module tb_grf_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        p_valid = 1'b0, m_valid = 1'b0;
   logic [4:0]  p_a3 = 5'd0, m_a3 = 5'd0, q_a = 5'd0;
   logic [31:0] p_wd = 32'd0, p_pc = 32'd0, m_wd = 32'd0, m_pc = 32'd0;

   logic        p_ready, m_ready, grf_we, q_hit;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd, grf_pc, q_wd;
   logic [2:0]  starve_cnt;

   logic        p_ready1, m_ready1, grf_we1, q_hit1;
   logic [4:0]  grf_a31;
   logic [31:0] grf_wd1, grf_pc1, q_wd1;
   logic [2:0]  starve_cnt1;

   typedef struct {
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] pc;
   } wr_t;

   wr_t exp_q[$];
   int  errors = 0;
   int  checks = 0;
   logic sb_en = 1'b0;
   logic sb_sel = 1'b0;

   grf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .p_valid(p_valid), .p_ready(p_ready), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
      .m_valid(m_valid), .m_ready(m_ready), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
      .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
      .q_a(q_a), .q_hit(q_hit), .q_wd(q_wd), .starve_cnt(starve_cnt)
   );

   grf_wb_arbiter #(.STARVE_LIMIT(1), .CNT_W(3)) dut1 (
      .clk(clk), .reset(reset),
      .p_valid(p_valid), .p_ready(p_ready1), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
      .m_valid(m_valid), .m_ready(m_ready1), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
      .grf_we(grf_we1), .grf_a3(grf_a31), .grf_wd(grf_wd1), .grf_pc(grf_pc1),
      .q_a(q_a), .q_hit(q_hit1), .q_wd(q_wd1), .starve_cnt(starve_cnt1)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: one expected entry per monitored edge
   wr_t         e;
   logic        o_we;
   logic [4:0]  o_a3;
   logic [31:0] o_wd, o_pc;
   always @(posedge clk) begin
      if (sb_en) begin
         #1;
         o_we = sb_sel ? grf_we1 : grf_we;
         o_a3 = sb_sel ? grf_a31 : grf_a3;
         o_wd = sb_sel ? grf_wd1 : grf_wd;
         o_pc = sb_sel ? grf_pc1 : grf_pc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: no expected entry at t=%0t", $time);
         end else begin
            e = exp_q.pop_front();
            if (o_we !== e.we) begin
               errors++;
               $display("FAIL sb_we: got %0b expected %0b t=%0t", o_we, e.we, $time);
            end else if (e.we && (o_a3 !== e.a3 || o_wd !== e.wd || o_pc !== e.pc)) begin
               errors++;
               $display("FAIL sb_fields: got a3=%0d wd=%h pc=%h expected a3=%0d wd=%h pc=%h",
                        o_a3, o_wd, o_pc, e.a3, e.wd, e.pc);
            end
         end
      end
   end

   task automatic test_reset();
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (grf_we !== 1'b0 || grf_a3 !== 5'd0 || grf_wd !== 32'd0 || grf_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset_grf: got we=%0b a3=%0d wd=%h pc=%h expected all 0", grf_we, grf_a3, grf_wd, grf_pc);
      end
      checks++;
      if (starve_cnt !== 3'd0 || p_ready !== 1'b1 || m_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: got cnt=%0d p_ready=%0b m_ready=%0b expected 0 1 1", starve_cnt, p_ready, m_ready);
      end
      reset = 1'b1;
      @(posedge clk); #2;
      p_valid = 1'b1; p_a3 = 5'd5; p_wd = 32'h55; p_pc = 32'h100;
      @(posedge clk); #2;
      checks++;
      if (grf_we !== 1'b1 || grf_a3 !== 5'd5) begin
         errors++;
         $display("FAIL pre_reset_write: got we=%0b a3=%0d expected 1 5", grf_we, grf_a3);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (grf_we !== 1'b0 || grf_a3 !== 5'd0 || grf_wd !== 32'd0 || grf_pc !== 32'd0 || starve_cnt !== 3'd0) begin
         errors++;
         $display("FAIL midcycle_reset: got we=%0b a3=%0d wd=%h pc=%h cnt=%0d expected all 0",
                  grf_we, grf_a3, grf_wd, grf_pc, starve_cnt);
      end
      p_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #2;
         checks++;
         if (grf_we !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got we=%0b expected 0", grf_we);
         end
      end
   endtask

   task automatic test_p_write();
      sb_en = 1'b1;
      p_valid = 1'b1; p_a3 = 5'd5; p_wd = 32'h1234; p_pc = 32'h3000;
      @(negedge clk);
      checks++;
      if (p_ready !== 1'b1) begin
         errors++;
         $display("FAIL p_write_ready: got %0b expected 1", p_ready);
      end
      exp_q.push_back('{1'b1, 5'd5, 32'h1234, 32'h3000});
      @(posedge clk); #2;
      p_valid = 1'b0; q_a = 5'd5;
      #1;
      checks++;
      if (q_hit !== 1'b1 || q_wd !== 32'h1234) begin
         errors++;
         $display("FAIL query_hit: got hit=%0b wd=%h expected 1 00001234", q_hit, q_wd);
      end
   endtask

   task automatic test_zero_dest();
      p_valid = 1'b1; p_a3 = 5'd0; p_wd = 32'hDEAD; p_pc = 32'h3004;
      @(negedge clk);
      checks++;
      if (p_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_ready: got %0b expected 1", p_ready);
      end
      exp_q.push_back('{1'b0, 5'd0, 32'd0, 32'd0});
      @(posedge clk); #2;
      p_valid = 1'b0; q_a = 5'd0;
      #1;
      checks++;
      if (q_hit !== 1'b0) begin
         errors++;
         $display("FAIL zero_query: got hit=%0b expected 0", q_hit);
      end
      q_a = 5'd5;
      #1;
      checks++;
      if (q_hit !== 1'b0) begin
         errors++;
         $display("FAIL idle_query: got hit=%0b expected 0", q_hit);
      end
      sb_en = 1'b0;
   endtask

   task automatic test_starvation();
      sb_en = 1'b1;
      m_valid = 1'b1; m_a3 = 5'd8; m_wd = 32'hBEEF; m_pc = 32'h4000;
      for (int c = 1; c <= 6; c++) begin
         if (c == 6) m_valid = 1'b0;
         p_valid = 1'b1; p_a3 = 5'(c + 10); p_wd = 32'h1000 + 32'(c); p_pc = 32'h3000 + 32'(4 * c);
         @(negedge clk);
         checks++;
         if (p_ready !== (c != 5) || m_ready !== (c == 5) || starve_cnt !== 3'((c <= 5) ? c - 1 : 0)) begin
            errors++;
            $display("FAIL starve_c%0d: got p_ready=%0b m_ready=%0b cnt=%0d expected %0b %0b %0d",
                     c, p_ready, m_ready, starve_cnt, (c != 5), (c == 5), (c <= 5) ? c - 1 : 0);
         end
         if (c == 5) exp_q.push_back('{1'b1, 5'd8, 32'hBEEF, 32'h4000});
         else        exp_q.push_back('{1'b1, p_a3, p_wd, p_pc});
         @(posedge clk); #2;
      end
   endtask

   task automatic test_p_drop();
      m_valid = 1'b1; m_a3 = 5'd12; m_wd = 32'hCAFE; m_pc = 32'h5000;
      for (int c = 1; c <= 4; c++) begin
         p_valid = (c < 3); p_a3 = 5'(c + 1); p_wd = 32'h2000 + 32'(c); p_pc = 32'h6000 + 32'(4 * c);
         if (c == 4) m_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (m_ready !== (c >= 3) || starve_cnt !== 3'((c <= 3) ? c - 1 : 0)) begin
            errors++;
            $display("FAIL pdrop_c%0d: got m_ready=%0b cnt=%0d expected %0b %0d",
                     c, m_ready, starve_cnt, (c >= 3), (c <= 3) ? c - 1 : 0);
         end
         if (c < 3)       exp_q.push_back('{1'b1, p_a3, p_wd, p_pc});
         else if (c == 3) exp_q.push_back('{1'b1, 5'd12, 32'hCAFE, 32'h5000});
         else             exp_q.push_back('{1'b0, 5'd0, 32'd0, 32'd0});
         @(posedge clk); #2;
      end
      sb_en = 1'b0;
   endtask

   task automatic test_limit_one();
      reset = 1'b0;
      #1 reset = 1'b1;
      sb_sel = 1'b1; sb_en = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         p_valid = (c < 7); p_a3 = 5'(c + 1); p_wd = 32'h7000 + 32'(c); p_pc = 32'h8000 + 32'(4 * c);
         m_valid = (c < 7);
         if (c % 2 == 1) begin
            m_a3 = 5'(20 + c); m_wd = 32'hA000 + 32'(c); m_pc = 32'h9000 + 32'(4 * c);
         end
         @(negedge clk);
         if (c < 7) begin
            checks++;
            if (p_ready1 !== (c % 2 == 1) || m_ready1 !== (c % 2 == 0) || starve_cnt1 !== 3'(1 - c % 2)) begin
               errors++;
               $display("FAIL limit1_c%0d: got p_ready=%0b m_ready=%0b cnt=%0d expected %0b %0b %0d",
                        c, p_ready1, m_ready1, starve_cnt1, (c % 2 == 1), (c % 2 == 0), 1 - c % 2);
            end
            if (c % 2 == 1) exp_q.push_back('{1'b1, p_a3, p_wd, p_pc});
            else            exp_q.push_back('{1'b1, m_a3, m_wd, m_pc});
         end else begin
            exp_q.push_back('{1'b0, 5'd0, 32'd0, 32'd0});
         end
         @(posedge clk); #2;
      end
      sb_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_p_write();
      test_zero_dest();
      test_starvation();
      test_p_drop();
      test_limit_one();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
